instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage pipeline; producer side of the IF/ID interface that InstructionDecode consumes.
- Owns the program counter and issues requests to instruction memory over a request/ready handshake.
- Drives the IF/ID register (instruction, programCounterOut, instructionValid).
- Obeys decode's pcWrite/ifIdWrite stall controls and branch/branchProgramCounter redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP, 32'h0000_0000, bubble instruction (ADD R0,R0,R0) inserted on stall or flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- pcWrite  input  1  from decode; 0 = hold PC (hazard stall).
- ifIdWrite  input  1  from decode; 0 = hold IF/ID register.
- branch  input  1  from decode; taken branch/redirect this cycle.
- branchProgramCounter  input  32  redirect target; valid when branch=1.
- imemRequest  output  1  fetch request to instruction memory.
- imemAddress  output  32  fetch address; stable while imemRequest=1.
- imemReady  input  1  memory accepts the request and returns imemData this cycle.
- imemData  input  32  fetched instruction; valid when imemRequest & imemReady.
- instruction  output  32  IF/ID instruction to decode.
- programCounterOut  output  32  IF/ID: fetch address + PC_STEP.
- instructionValid  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high. While reset=1 at an edge:
  - pc=RESET_PC, state=FETCH.
  - instruction=NOP, programCounterOut=0, instructionValid=0.
  - imemRequest=0, buffer cleared, redirect register cleared.
- First request is issued in the cycle after reset deasserts.
- Handshake: a transfer completes in a cycle where imemRequest=1 and imemReady=1. Once raised, imemRequest and imemAddress stay constant until that transfer completes. No request is ever withdrawn.
- States:
  - FETCH: imemRequest=1, imemAddress=pc.
    - ready & branch: discard data; pc=branchProgramCounter; IF/ID<=NOP, valid 0; stay FETCH.
    - ready & !branch & pcWrite & ifIdWrite: IF/ID<={imemData, pc+PC_STEP, valid 1}; pc+=PC_STEP; next address is issued the following cycle (1 instr/cycle at zero-wait memory).
    - ready & !branch & stalled (pcWrite=0 or ifIdWrite=0): buffer<={imemData, pc+PC_STEP}; IF/ID held; -> BUFFERED.
    - !ready & branch: redirect<=branchProgramCounter; IF/ID<=NOP, valid 0; -> DISCARD.
    - !ready & !branch & ifIdWrite=1: IF/ID<=NOP, valid 0 (memory-wait bubble).
    - !ready & !branch & ifIdWrite=0: IF/ID held.
  - BUFFERED: imemRequest=0.
    - branch: drop buffer; pc=branchProgramCounter; IF/ID<=NOP; -> FETCH.
    - pcWrite & ifIdWrite: IF/ID<=buffer, valid 1; pc+=PC_STEP; -> FETCH.
    - otherwise: hold.
  - DISCARD: imemRequest=1 at the old address until ready. IF/ID<=NOP when ifIdWrite=1.
    - ready: drop data; pc=redirect; -> FETCH.
    - A newer branch in DISCARD overwrites redirect (last branch wins).
- Priority: reset > branch > stall > normal advance. Branch flushes IF/ID even when ifIdWrite=0.
- Arithmetic: pc+PC_STEP is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. No alignment checking; target used verbatim.
- Reset mid-transfer (in FETCH or DISCARD): the request is abandoned; memory tolerates this.

Test Plan:
- Reset, then imemReady tied 1, imemData=pc-tagged words, no stalls -> imemAddress 0,4,8,12 on consecutive cycles; IF/ID programCounterOut 4,8,12 with valid=1 one cycle after each address.
- imemReady low 3 cycles at address 8 -> imemAddress held at 8, imemRequest stays 1; 3 NOP bubbles (valid=0); instruction at 8 appears the cycle after ready.
- ifIdWrite=pcWrite=0 for 2 cycles while ready returns 32'h0000_0840 at address 4 -> IF/ID holds the previous instruction, imemRequest=0; on release IF/ID=32'h0000_0840, programCounterOut=8, next imemAddress=8.
- branch=1, branchProgramCounter=32'h0000_0040 with zero-wait memory -> IF/ID=NOP, valid 0; next imemAddress=32'h40; programCounterOut 32'h44 after one more cycle.
- branch to 32'h80 while imemReady low at address 12 -> imemAddress stays 12 until ready; that data is discarded (never valid); next request at 32'h80.
- pc=32'hFFFF_FFFC, normal fetch -> programCounterOut=0, next imemAddress=0; assert reset mid-wait -> next cycle imemRequest=0, outputs at reset values.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches over a request/ready handshake to instruction memory and
// drives the IF/ID register. It honours decode stall controls and branch redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcWrite,
  input  logic        ifIdWrite,
  input  logic        branch,
  input  logic [31:0] branchProgramCounter,
  output logic        imemRequest,
  output logic [31:0] imemAddress,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instruction,
  output logic [31:0] programCounterOut,
  output logic        instructionValid
);

  typedef enum logic [1:0] {StFetch, StBuffered, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        valid_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic [31:0] redirect_q;

  logic [31:0] pc_inc;
  logic        xfer;

  assign pc_inc = pc_q + PC_STEP;
  assign xfer   = req_q & imemReady;

  assign imemRequest       = req_q;
  assign imemAddress       = pc_q;
  assign instruction       = instr_q;
  assign programCounterOut = pc_out_q;
  assign instructionValid  = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      instr_q     <= NOP;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      redirect_q  <= '0;
    end else begin
      req_q <= 1'b1;
      case (state_q)
        StFetch: begin
          if (xfer) begin
            if (branch) begin
              pc_q    <= branchProgramCounter;
              instr_q <= NOP;
              valid_q <= 1'b0;
            end else if (pcWrite && ifIdWrite) begin
              instr_q  <= imemData;
              pc_out_q <= pc_inc;
              valid_q  <= 1'b1;
              pc_q     <= pc_inc;
            end else begin
              // Park the fetched word so the request can complete despite the stall.
              buf_instr_q <= imemData;
              buf_pc_q    <= pc_inc;
              state_q     <= StBuffered;
              req_q       <= 1'b0;
            end
          end else if (branch) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
            if (req_q) begin
              // A raised request cannot be withdrawn; wait it out, then redirect.
              redirect_q <= branchProgramCounter;
              state_q    <= StDiscard;
            end else begin
              pc_q <= branchProgramCounter;
            end
          end else if (ifIdWrite) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
          end
        end
        StBuffered: begin
          req_q <= 1'b0;
          if (branch) begin
            pc_q    <= branchProgramCounter;
            instr_q <= NOP;
            valid_q <= 1'b0;
            state_q <= StFetch;
            req_q   <= 1'b1;
          end else if (pcWrite && ifIdWrite) begin
            instr_q  <= buf_instr_q;
            pc_out_q <= buf_pc_q;
            valid_q  <= 1'b1;
            pc_q     <= pc_inc;
            state_q  <= StFetch;
            req_q    <= 1'b1;
          end
        end
        StDiscard: begin
          if (branch || ifIdWrite) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
          end
          if (imemReady) begin
            pc_q    <= branch ? branchProgramCounter : redirect_q;
            state_q <= StFetch;
          end else if (branch) begin
            redirect_q <= branchProgramCounter;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected fetch addresses and IF/ID
// words into queues; independent monitors pop and compare when the DUT presents them.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifid_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        branch;
  logic [31:0] branchProgramCounter;
  logic        imemRequest;
  logic [31:0] imemAddress;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] instruction;
  logic [31:0] programCounterOut;
  logic        instructionValid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  ifid_t       exp_ifid_q[$];

  always #5 clk = ~clk;

  // Address-tagged memory contents: word = (addr << 4) + 0x800.
  assign imemData = (imemAddress << 4) + 32'h0000_0800;

  instruction_fetch dut (
    .clk                  (clk),
    .reset                (reset),
    .pcWrite              (pcWrite),
    .ifIdWrite            (ifIdWrite),
    .branch               (branch),
    .branchProgramCounter (branchProgramCounter),
    .imemRequest          (imemRequest),
    .imemAddress          (imemAddress),
    .imemReady            (imemReady),
    .imemData             (imemData),
    .instruction          (instruction),
    .programCounterOut    (programCounterOut),
    .instructionValid     (instructionValid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ifid(input logic [31:0] instr, input logic [31:0] pc);
    ifid_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_ifid_q.push_back(e);
  endtask

  // Address monitor: every completed transfer must match the next expected address.
  always @(negedge clk) begin
    if (imemRequest === 1'b1 && imemReady === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_xfer", imemAddress, 32'hxxxx_xxxx);
      end else begin
        chk("xfer_addr", imemAddress, exp_addr_q.pop_front());
      end
    end
  end

  // IF/ID monitor: a newly presented valid word is popped; bubbles must carry NOP.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;
  always @(negedge clk) begin
    if (instructionValid === 1'b1) begin
      if (!(prev_valid && prev_pc == programCounterOut)) begin
        if (exp_ifid_q.size() == 0) begin
          chk("unexpected_ifid", programCounterOut, 32'hxxxx_xxxx);
        end else begin
          ifid_t e;
          e = exp_ifid_q.pop_front();
          chk("ifid_instr", instruction, e.instr);
          chk("ifid_pc", programCounterOut, e.pc);
        end
      end
    end else begin
      chk("bubble_nop", instruction, 32'h0000_0000);
    end
    prev_valid = instructionValid;
    prev_pc    = programCounterOut;
  end

  initial begin
    reset = 1'b1;
    pcWrite = 1'b1;
    ifIdWrite = 1'b1;
    branch = 1'b0;
    branchProgramCounter = '0;
    imemReady = 1'b0;
    repeat (2) tick();
    chk("rst_req", {31'b0, imemRequest}, 32'd0);
    chk("rst_valid", {31'b0, instructionValid}, 32'd0);
    chk("rst_pcout", programCounterOut, 32'd0);
    chk("rst_addr", imemAddress, 32'd0);

    // Zero-wait sequential fetch.
    reset = 1'b0;
    imemReady = 1'b1;
    exp_addr_q.push_back(32'd0);
    exp_addr_q.push_back(32'd4);
    push_ifid(32'h0000_0800, 32'd4);
    push_ifid(32'h0000_0840, 32'd8);
    tick();
    chk("first_req", {31'b0, imemRequest}, 32'd1);
    chk("first_addr", imemAddress, 32'd0);
    tick();
    tick();

    // Memory wait at address 8.
    imemReady = 1'b0;
    repeat (3) begin
      tick();
      chk("wait_req", {31'b0, imemRequest}, 32'd1);
      chk("wait_addr", imemAddress, 32'd8);
      chk("wait_valid", {31'b0, instructionValid}, 32'd0);
    end
    imemReady = 1'b1;
    exp_addr_q.push_back(32'd8);
    push_ifid(32'h0000_0880, 32'd12);
    tick();
    chk("after_wait_addr", imemAddress, 32'd12);

    // Stall while the fetch at 12 completes: word is buffered, IF/ID held.
    pcWrite = 1'b0;
    ifIdWrite = 1'b0;
    exp_addr_q.push_back(32'd12);
    repeat (2) begin
      tick();
      chk("stall_req", {31'b0, imemRequest}, 32'd0);
      chk("stall_instr", instruction, 32'h0000_0880);
      chk("stall_pcout", programCounterOut, 32'd12);
    end
    pcWrite = 1'b1;
    ifIdWrite = 1'b1;
    push_ifid(32'h0000_08C0, 32'd16);
    tick();
    chk("release_addr", imemAddress, 32'd16);
    chk("release_req", {31'b0, imemRequest}, 32'd1);

    // Taken branch with zero-wait memory: fetched word at 16 is dropped.
    branch = 1'b1;
    branchProgramCounter = 32'h0000_0040;
    exp_addr_q.push_back(32'd16);
    tick();
    chk("br_valid", {31'b0, instructionValid}, 32'd0);
    chk("br_addr", imemAddress, 32'h0000_0040);
    branch = 1'b0;
    exp_addr_q.push_back(32'h0000_0040);
    push_ifid(32'h0000_0C00, 32'h0000_0044);
    tick();

    // Branch while memory is waiting at 0x44: the pending fetch is discarded.
    imemReady = 1'b0;
    branch = 1'b1;
    branchProgramCounter = 32'h0000_0080;
    tick();
    chk("disc_req", {31'b0, imemRequest}, 32'd1);
    chk("disc_addr", imemAddress, 32'h0000_0044);
    branch = 1'b0;
    tick();
    chk("disc_addr_hold", imemAddress, 32'h0000_0044);
    imemReady = 1'b1;
    exp_addr_q.push_back(32'h0000_0044);
    exp_addr_q.push_back(32'h0000_0080);
    push_ifid(32'h0000_1000, 32'h0000_0084);
    tick();
    chk("redirect_addr", imemAddress, 32'h0000_0080);
    chk("disc_valid", {31'b0, instructionValid}, 32'd0);
    tick();

    // PC wrap at the top of the address space.
    branch = 1'b1;
    branchProgramCounter = 32'hFFFF_FFFC;
    exp_addr_q.push_back(32'h0000_0084);
    tick();
    chk("wrap_addr", imemAddress, 32'hFFFF_FFFC);
    branch = 1'b0;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    push_ifid(32'h0000_07C0, 32'd0);
    tick();
    chk("wrap_next_addr", imemAddress, 32'd0);
    chk("wrap_pcout", programCounterOut, 32'd0);

    // Reset in the middle of a memory wait.
    imemReady = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_req", {31'b0, imemRequest}, 32'd0);
    chk("mid_rst_valid", {31'b0, instructionValid}, 32'd0);
    chk("mid_rst_instr", instruction, 32'h0000_0000);
    chk("mid_rst_pcout", programCounterOut, 32'd0);
    chk("mid_rst_addr", imemAddress, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    chk("addr_queue_left", exp_addr_q.size(), 32'd0);
    chk("ifid_queue_left", exp_ifid_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
